// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the alu sequencing front-end.
// Flag vectors are always packed {C,S,Z,P}.
package alu_ctrl_pkg;

    localparam int WIDTH = 8;
    localparam int OPW   = 4;
    localparam int CNTW  = 4;

    typedef enum logic [1:0] {
        KIND_EXEC       = 2'b00,
        KIND_LOAD_ACC   = 2'b01,
        KIND_LOAD_FLAGS = 2'b10,
        KIND_READ       = 2'b11
    } cmd_kind_e;

    localparam int FLAG_C = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_P = 0;

    localparam logic [OPW-1:0] OP_ADD = 4'h0;
    localparam logic [OPW-1:0] OP_AND = 4'h1;
    localparam logic [OPW-1:0] OP_XOR = 4'h2;
    localparam logic [OPW-1:0] OP_RTC = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic [3:0] pack_flags(input logic c, input logic s,
                                              input logic z, input logic p);
        return {c, s, z, p};
    endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Command, response and alu-side signals of the sequencing front-end.
// slave = the controller, master = its environment (command source, sink, alu).
interface alu_ctrl_if;
    import alu_ctrl_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_kind;
    logic [OPW-1:0]   cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNTW-1:0]  cmd_count;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [3:0]       res_flags;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic             alu_cin;
    logic             alu_sin;
    logic             alu_zin;
    logic             alu_pin;
    logic [WIDTH-1:0] alu_out;
    logic             alu_c;
    logic             alu_s;
    logic             alu_z;
    logic             alu_p;

    modport slave (
        input  cmd_valid, cmd_kind, cmd_op, cmd_data, cmd_count,
        input  res_ready,
        input  alu_out, alu_c, alu_s, alu_z, alu_p,
        output cmd_ready,
        output res_valid, res_data, res_flags,
        output alu_a, alu_b, alu_op, alu_cin, alu_sin, alu_zin, alu_pin
    );

    modport master (
        output cmd_valid, cmd_kind, cmd_op, cmd_data, cmd_count,
        output res_ready,
        output alu_out, alu_c, alu_s, alu_z, alu_p,
        input  cmd_ready,
        input  res_valid, res_data, res_flags,
        input  alu_a, alu_b, alu_op, alu_cin, alu_sin, alu_zin, alu_pin
    );

endinterface

// File: rtl/alu_ctrl.sv
// Sequencing front-end for the combinational 8-bit alu: owns the accumulator and
// CSZP flags, iterates an op count+1 times through them, and returns the result.
module alu_ctrl
    import alu_ctrl_pkg::*;
(
    input logic       clk,
    input logic       rst,
    alu_ctrl_if.slave bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [OPW-1:0]   op_q,    op_d;
    logic [3:0]       flags_q, flags_d;
    logic [CNTW-1:0]  iter_q,  iter_d;
    logic             accept_s;

    assign accept_s = bus.cmd_valid && (state_q == ST_IDLE) && !rst;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            op_q    <= {OPW{1'b0}};
            flags_q <= 4'b0000;
            iter_q  <= {CNTW{1'b0}};
        end else begin
            acc_q   <= acc_d;
            b_q     <= b_d;
            op_q    <= op_d;
            flags_q <= flags_d;
            iter_q  <= iter_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = (bus.cmd_kind == KIND_EXEC) ? ST_RUN : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (iter_q == {CNTW{1'b0}}) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: command latching and per-iteration alu capture
    always_comb begin
        acc_d   = acc_q;
        b_d     = b_q;
        op_d    = op_q;
        flags_d = flags_q;
        iter_d  = iter_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (bus.cmd_kind)
                        KIND_EXEC: begin
                            b_d    = bus.cmd_data;
                            op_d   = bus.cmd_op;
                            iter_d = bus.cmd_count;
                        end
                        KIND_LOAD_ACC:   acc_d   = bus.cmd_data;
                        KIND_LOAD_FLAGS: flags_d = bus.cmd_data[3:0];
                        default:         acc_d   = acc_q;
                    endcase
                end else begin
                    acc_d = acc_q;
                end
            end
            ST_RUN: begin
                acc_d   = bus.alu_out;
                flags_d = pack_flags(bus.alu_c, bus.alu_s, bus.alu_z, bus.alu_p);
                // Saturate at zero: the final iteration leaves the counter at 0.
                if (iter_q != {CNTW{1'b0}}) begin
                    iter_d = iter_q - 1'b1;
                end else begin
                    iter_d = iter_q;
                end
            end
            default: acc_d = acc_q;
        endcase
    end

    // Outputs decoded from registers only (cmd_ready also blocked during reset)
    always_comb begin
        bus.cmd_ready = (state_q == ST_IDLE) && !rst;
        bus.res_valid = (state_q == ST_DONE);
        bus.res_data  = acc_q;
        bus.res_flags = flags_q;
        bus.alu_a     = acc_q;
        bus.alu_b     = b_q;
        bus.alu_op    = op_q;
        bus.alu_cin   = flags_q[FLAG_C];
        bus.alu_sin   = flags_q[FLAG_S];
        bus.alu_zin   = flags_q[FLAG_Z];
        bus.alu_pin   = flags_q[FLAG_P];
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl with a small behavioural alu attached and a
// command-level reference model of the accumulator/flags.
module tb_alu_ctrl;
    import alu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_ctrl_if bus ();

    alu_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] m_acc   = 8'h00;
    logic [3:0] m_flags = 4'b0000;

    // Bench alu: returns {C,S,Z,P,out}
    function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op, input logic [3:0] fl);
        logic [8:0] w;
        logic [7:0] o;
        logic       c;
        case (op)
            OP_ADD:  begin w = {1'b0, a} + {1'b0, b}; o = w[7:0]; c = w[8]; end
            OP_AND:  begin o = a & b; c = 1'b0; end
            OP_XOR:  begin o = a ^ b; c = fl[3]; end
            OP_RTC:  begin o = {a[6:0], fl[3]}; c = a[7]; end
            default: begin o = a; c = fl[3]; end
        endcase
        return {c, o[7], (o == 8'h00), ~^o, o};
    endfunction

    always_comb begin
        {bus.alu_c, bus.alu_s, bus.alu_z, bus.alu_p, bus.alu_out} =
            alu_fn(bus.alu_a, bus.alu_b, bus.alu_op,
                   {bus.alu_cin, bus.alu_sin, bus.alu_zin, bus.alu_pin});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a command (called just after a negedge) and wait for its accept edge.
    task automatic send(input logic [1:0] kind, input logic [3:0] op,
                        input logic [7:0] data, input logic [3:0] count);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_kind  = kind;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_count = count;
        while (!bus.cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", bus.cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Full command: model update, per-iteration checks, latency, response, backpressure.
    task automatic run_cmd(input logic [1:0] kind, input logic [3:0] op,
                           input logic [7:0] data, input logic [3:0] count,
                           input int hold, input logic hold_valid);
        logic [7:0]  a_exp [0:15];
        logic        cin_exp [0:15];
        logic [11:0] r;
        int          k;
        int          exp_lat;
        case (kind)
            KIND_EXEC: begin
                for (int i = 0; i <= int'(count); i++) begin
                    a_exp[i]   = m_acc;
                    cin_exp[i] = m_flags[3];
                    r = alu_fn(m_acc, data, op, m_flags);
                    m_acc   = r[7:0];
                    m_flags = r[11:8];
                end
                exp_lat = int'(count) + 2;
            end
            KIND_LOAD_ACC:   begin m_acc = data; exp_lat = 1; end
            KIND_LOAD_FLAGS: begin m_flags = data[3:0]; exp_lat = 1; end
            default:         exp_lat = 1;
        endcase
        send(kind, op, data, count);
        k = 1;
        while (!bus.res_valid && k < 40) begin
            if (k - 1 < 16) begin
                chk("run_alu_a", bus.alu_a, a_exp[k-1]);
                chk("run_alu_cin", bus.alu_cin, cin_exp[k-1]);
                chk("run_alu_b", bus.alu_b, data);
                chk("run_cmd_ready", bus.cmd_ready, 0);
            end
            @(negedge clk);
            k++;
        end
        chk("latency", k, exp_lat);
        chk("res_data", bus.res_data, m_acc);
        chk("res_flags", bus.res_flags, m_flags);
        bus.res_ready = 1'b0;
        if (hold_valid) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_kind  = KIND_READ;
        end
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", bus.res_valid, 1);
            chk("hold_data", bus.res_data, m_acc);
            chk("hold_flags", bus.res_flags, m_flags);
            chk("hold_cmd_ready", bus.cmd_ready, 0);
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("post_res_valid", bus.res_valid, 0);
        chk("post_cmd_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] ops [0:3];
        ops[0] = OP_ADD; ops[1] = OP_AND; ops[2] = OP_XOR; ops[3] = OP_RTC;
        bus.cmd_valid = 1'b0;
        bus.cmd_kind  = 2'b00;
        bus.cmd_op    = 4'h0;
        bus.cmd_data  = 8'h00;
        bus.cmd_count = 4'h0;
        bus.res_ready = 1'b0;

        // Power-on reset
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("init_acc", bus.alu_a, 8'h00);
        chk("init_flags", {bus.alu_cin, bus.alu_sin, bus.alu_zin, bus.alu_pin}, 4'b0000);
        chk("init_b", bus.alu_b, 8'h00);
        chk("init_op", bus.alu_op, 4'h0);
        chk("init_cmd_ready", bus.cmd_ready, 1);

        // Reset in the middle of a 6-iteration EXEC aborts it
        run_cmd(KIND_LOAD_ACC, 4'h0, 8'h37, 4'h0, 0, 1'b0);
        send(KIND_EXEC, OP_ADD, 8'h11, 4'h5);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_cmd_ready", bus.cmd_ready, 0);
            chk("midrst_res_valid", bus.res_valid, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_acc", bus.alu_a, 8'h00);
        chk("midrst_flags", {bus.alu_cin, bus.alu_sin, bus.alu_zin, bus.alu_pin}, 4'b0000);
        chk("midrst_ready_after", bus.cmd_ready, 1);
        m_acc   = 8'h00;
        m_flags = 4'b0000;
        repeat (8) begin
            @(negedge clk);
            chk("midrst_no_resp", bus.res_valid, 0);
        end

        // Single add: result 0x20, response two cycles after accept
        run_cmd(KIND_LOAD_ACC, 4'h0, 8'h00, 4'h0, 0, 1'b0);
        run_cmd(KIND_EXEC, OP_ADD, 8'h20, 4'h0, 1, 1'b0);
        chk("add_0x20", m_acc, 8'h20);

        // Chained add x4 from 1 gives 5
        run_cmd(KIND_LOAD_ACC, 4'h0, 8'h01, 4'h0, 0, 1'b0);
        run_cmd(KIND_LOAD_FLAGS, 4'h0, 8'h00, 4'h0, 0, 1'b0);
        run_cmd(KIND_EXEC, OP_ADD, 8'h01, 4'h3, 0, 1'b0);
        chk("chain_0x05", bus.alu_a, 8'h05);

        // Rotate through carry, 9 iterations, carry-in tracked each cycle
        run_cmd(KIND_LOAD_ACC, 4'h0, 8'h01, 4'h0, 0, 1'b0);
        run_cmd(KIND_LOAD_FLAGS, 4'h0, 8'h08, 4'h0, 0, 1'b0);
        run_cmd(KIND_EXEC, OP_RTC, 8'h00, 4'h8, 0, 1'b0);

        // Backpressure with a command waiting
        run_cmd(KIND_EXEC, OP_XOR, 8'h5A, 4'h2, 5, 1'b1);

        // READ after LOAD_FLAGS 0101 with acc 0xAE
        run_cmd(KIND_LOAD_ACC, 4'h0, 8'hAE, 4'h0, 0, 1'b0);
        run_cmd(KIND_LOAD_FLAGS, 4'h0, 8'h05, 4'h0, 0, 1'b0);
        run_cmd(KIND_READ, 4'h0, 8'hFF, 4'hF, 0, 1'b0);
        chk("read_acc_kept", bus.alu_a, 8'hAE);
        chk("read_flags_kept", {bus.alu_cin, bus.alu_sin, bus.alu_zin, bus.alu_pin}, 4'b0101);

        // Maximum count: 16 iterations, no wrap
        run_cmd(KIND_LOAD_ACC, 4'h0, 8'h03, 4'h0, 0, 1'b0);
        run_cmd(KIND_EXEC, OP_ADD, 8'h07, 4'hF, 0, 1'b0);

        // Randomized command stream
        for (int t = 0; t < 30; t++) begin
            run_cmd(2'($urandom_range(0, 3)), ops[$urandom_range(0, 3)],
                    8'($urandom), 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
Sequencing front-end for the 8-bit flag-carrying alu. It accepts commands over a valid/ready interface and holds the accumulator and CSZP flag register. It drives the alu operand, op and flag inputs, and captures the alu result and flags back into its registers. Repeated ops are chained through the accumulator and flags, so a rotate or add can be iterated N times without external feedback. It returns each command's result on a valid/ready response port.

Parameters:
WIDTH, 8, data/accumulator width (matches alu a/b/out)
OPW, 4, alu op field width
CNTW, 4, repeat-count width; a command executes count+1 iterations

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_kind  input  2  00 EXEC, 01 LOAD_ACC, 10 LOAD_FLAGS, 11 READ
cmd_op  input  OPW  alu op for EXEC
cmd_data  input  WIDTH  b operand (EXEC); acc value (LOAD_ACC); data[3:0]={C,S,Z,P} (LOAD_FLAGS)
cmd_count  input  CNTW  extra iterations for EXEC; ignored otherwise
res_valid  output  1  response present
res_ready  input  1  consumer accepts response
res_data  output  WIDTH  accumulator after command
res_flags  output  4  {C,S,Z,P} after command
alu_a  output  WIDTH  to alu a (= acc)
alu_b  output  WIDTH  to alu b (= latched cmd_data)
alu_op  output  OPW  to alu op (= latched cmd_op)
alu_cin, alu_sin, alu_zin, alu_pin  output  1 each  to alu Cin/Sin/Zin/Pin (= flag register)
alu_out  input  WIDTH  from alu out
alu_c, alu_s, alu_z, alu_p  input  1 each  from alu C/S/Z/P

Behaviour:
- The alu is combinational, so one iteration completes per clock: alu_* outputs are driven from registers, and results are captured on the next edge.
- Reset (sync, rst=1 at edge): state=IDLE, acc=0, flags=0000, b_reg=0, op_reg=0, iter=0, res_valid=0. cmd_ready=0 while rst is high.
- Reset mid-command aborts the command: no response, registers are cleared as above.
- IDLE: cmd_ready=1. On a handshake (cmd_valid&cmd_ready) at edge T:
  - EXEC: latch b_reg=cmd_data, op_reg=cmd_op, iter=cmd_count; go RUN.
  - LOAD_ACC: acc=cmd_data; go DONE.
  - LOAD_FLAGS: flags=cmd_data[3:0]; go DONE.
  - READ: no change; go DONE.
- RUN: cmd_ready=0. At each edge: acc=alu_out, flags={alu_c,alu_s,alu_z,alu_p}.
  - If iter==0, go DONE; else iter=iter-1.
  - New flags feed alu_*in for the next iteration.
  - EXEC latency: count+1 cycles in RUN, then res_valid rises on the following cycle. Example: count=0 gives res_valid at T+2.
  - count=all-ones gives 2^CNTW iterations; the counter does not wrap past 0.
- DONE: res_valid=1, res_data=acc, res_flags=flags, all held stable until res_ready=1 at an edge, then go IDLE.
  - cmd_ready stays 0 in DONE, so a new command is accepted at the earliest one cycle after the response handshake (no bypass).
  - LOAD/READ latency: res_valid at T+1.
- cmd_valid while cmd_ready=0 is ignored; the source must hold it.
- res_ready while res_valid=0 is ignored.
- Arithmetic and flag semantics belong entirely to the alu; this block never modifies alu_out or the flags. Width is always WIDTH, with no extension.
- alu_a/alu_b/alu_op/flag inputs are driven in every state; values outside RUN are don't-care to the alu but are deterministic register contents.

Decomposition:
- Shared package (alu_pkg): WIDTH/OPW defaults; cmd_kind encodings; flag bit positions C=3, S=2, Z=1, P=0; alu op codes (ADD=4'h0, RTC=4'b1110, ...).
- Shared package, ctrl-local: state encoding IDLE/RUN/DONE.
- No sub-module is needed. The alu is instantiated beside this block at the level above, not inside it.

Test Plan:
- Reset: hold rst 2 cycles mid-RUN (count=5) -> res_valid=0, acc=0x00, flags=0000, cmd_ready=1 the cycle after rst drops; no response emitted.
- LOAD_ACC 0x00, then EXEC op=4'h0 b=0x20 count=0 -> res_data=0x20, res_valid exactly 2 cycles after the accept edge.
- Chained EXEC: LOAD_ACC 0x01, LOAD_FLAGS 0000, EXEC op=4'h0 b=0x01 count=3 -> 4 RUN cycles, res_data=0x05.
- Flag carry-in: LOAD_ACC 0x01, LOAD_FLAGS 1000, EXEC op=4'b1110 count=8 -> alu_cin tracks the previous alu_c every cycle; res_flags equal the alu's C/S/Z/P from the 9th iteration.
- Backpressure: hold res_ready=0 for 5 cycles with cmd_valid=1 -> res_data/res_flags stable, cmd_ready=0 throughout; after res_ready pulse, cmd_ready=1 the next cycle.
- READ after LOAD_FLAGS 0101 with acc=0xAE -> res_data=0xAE, res_flags=0101 at T+1; state unchanged.
